// File: rtl/axi_pkg.sv
// -----------------------------------------------------------------------------
// axi_pkg
// Shared AXI read-address definitions for the interconnect decoder slice:
// default channel widths, response and burst encodings, and the AR payload
// structure (id, addr, len, size, burst) used wherever a whole AR beat is
// handled as one value.
// -----------------------------------------------------------------------------
package axi_pkg;

    localparam int AXI_ID_W   = 4;   // master-side ID width
    localparam int AXI_IDS_W  = 8;   // slave-side ID width (master index prepended)
    localparam int AXI_ADDR_W = 32;
    localparam int AXI_LEN_W  = 4;
    localparam int AXI_SIZE_W = 3;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    typedef struct packed {
        logic [AXI_IDS_W-1:0]  id;
        logic [AXI_ADDR_W-1:0] addr;
        logic [AXI_LEN_W-1:0]  len;
        logic [AXI_SIZE_W-1:0] size;
        logic [1:0]            burst;
    } ar_payload_t;

endpackage

// File: rtl/axi_default_slave_rd.sv
// -----------------------------------------------------------------------------
// axi_default_slave_rd
// Read side of the built-in default slave. Every AR that matches no mapped
// slave is answered here with len+1 DECERR beats carrying zero data.
//
// Ports:
//   clk, srst      clock, synchronous active-high reset
//   start          consume one AR (only honoured while idle is high)
//   start_id       slave-side ID of that AR
//   start_len      burst length of that AR (beats - 1)
//   idle           high while no burst is being returned
//   rid/rdata/rresp/rlast/rvalid   R channel towards the interconnect R mux
//   rready         R mux ready
// -----------------------------------------------------------------------------
module axi_default_slave_rd
    import axi_pkg::*;
#(
    parameter int IDS_W  = 8,
    parameter int LEN_W  = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              srst,
    input  logic              start,
    input  logic [IDS_W-1:0]  start_id,
    input  logic [LEN_W-1:0]  start_len,
    output logic              idle,
    output logic [IDS_W-1:0]  rid,
    output logic [DATA_W-1:0] rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready
);

    typedef enum logic {
        S_IDLE,
        S_RESP
    } state_t;

    state_t             state_reg, state_next;
    logic [LEN_W-1:0]   cnt_reg, cnt_next;
    logic [IDS_W-1:0]   rid_reg, rid_next;

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            rid_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            rid_reg   <= rid_next;
        end
    end

    // cnt_reg holds the number of beats still to send after the current one,
    // so the beat presented with cnt_reg == 0 is the last.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        rid_next   = rid_reg;
        idle       = 1'b0;
        rvalid     = 1'b0;
        rresp      = AXI_RESP_OKAY;
        rlast      = 1'b0;
        case (state_reg)
            S_IDLE: begin
                idle = 1'b1;
                if (start) begin
                    rid_next   = start_id;
                    cnt_next   = start_len;
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                rvalid = 1'b1;
                rresp  = AXI_RESP_DECERR;
                rlast  = (cnt_reg == '0);
                if (rready) begin
                    if (cnt_reg == '0) begin
                        state_next = S_IDLE;
                    end else begin
                        cnt_next = cnt_reg - LEN_W'(1);
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign rid   = rid_reg;
    assign rdata = '0;

endmodule

// File: rtl/ar_decoder_n.sv
// -----------------------------------------------------------------------------
// ar_decoder_n
// Registered AXI read-address decoder for one master port. An accepted AR is
// held in a one-entry register together with its decoded target: a one-hot
// slave select, or a flag marking it for the built-in DECERR default slave.
//
// Ports:
//   ACLK, ARESET                 clock, synchronous active-high reset
//   ARID..ARVALID, ARREADY       master AR channel
//   ARID_S..ARVALID_S, ARREADY_S per-slave AR channels (packed, slave 0 in LSBs);
//                                payload is broadcast, only ARVALID_S is per slave
//   RID_D..RVALID_D, RREADY_D    R channel of the default slave
// -----------------------------------------------------------------------------
module ar_decoder_n
    import axi_pkg::*;
#(
    parameter int                         NUM_SLAVES = 2,
    parameter int                         ADDR_W     = AXI_ADDR_W,
    parameter int                         ID_W       = AXI_ID_W,
    parameter int                         IDS_W      = AXI_IDS_W,
    parameter int                         LEN_W      = AXI_LEN_W,
    parameter int                         SIZE_W     = AXI_SIZE_W,
    parameter int                         DATA_W     = 32,
    parameter logic [3:0]                 MASTER_IDX = 4'd0,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_BASE = {32'h0001_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLV_MASK = {32'hFFFF_0000, 32'hFFFF_0000}
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic [ID_W-1:0]              ARID,
    input  logic [ADDR_W-1:0]            ARADDR,
    input  logic [LEN_W-1:0]             ARLEN,
    input  logic [SIZE_W-1:0]            ARSIZE,
    input  logic [1:0]                   ARBURST,
    input  logic                         ARVALID,
    output logic                         ARREADY,
    output logic [NUM_SLAVES*IDS_W-1:0]  ARID_S,
    output logic [NUM_SLAVES*ADDR_W-1:0] ARADDR_S,
    output logic [NUM_SLAVES*LEN_W-1:0]  ARLEN_S,
    output logic [NUM_SLAVES*SIZE_W-1:0] ARSIZE_S,
    output logic [NUM_SLAVES*2-1:0]      ARBURST_S,
    output logic [NUM_SLAVES-1:0]        ARVALID_S,
    input  logic [NUM_SLAVES-1:0]        ARREADY_S,
    output logic [IDS_W-1:0]             RID_D,
    output logic [DATA_W-1:0]            RDATA_D,
    output logic [1:0]                   RRESP_D,
    output logic                         RLAST_D,
    output logic                         RVALID_D,
    input  logic                         RREADY_D
);

    // ---------------- input-side decode ----------------
    logic [NUM_SLAVES-1:0] hit;
    logic [NUM_SLAVES-1:0] sel_in;
    logic                  dflt_in;
    logic [IDS_W-1:0]      id_in;

    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_hit
        assign hit[gi] = ((ARADDR & SLV_MASK[gi*ADDR_W +: ADDR_W])
                          == SLV_BASE[gi*ADDR_W +: ADDR_W]);
    end

    // Walk from the top index down so the lowest hitting index is written
    // last and wins on overlapping windows.
    always_comb begin
        sel_in = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                sel_in    = '0;
                sel_in[i] = 1'b1;
            end
        end
    end

    assign dflt_in = ~|hit;
    assign id_in   = IDS_W'({MASTER_IDX, ARID});

    // ---------------- one-entry pipeline register ----------------
    logic                  hold_v_reg;
    logic [NUM_SLAVES-1:0] sel_reg;
    logic                  dflt_reg;
    logic [IDS_W-1:0]      id_reg;
    logic [ADDR_W-1:0]     addr_reg;
    logic [LEN_W-1:0]      len_reg;
    logic [SIZE_W-1:0]     size_reg;
    logic [1:0]            burst_reg;

    logic accept;
    logic out_fire;
    logic ds_idle;
    logic ds_start;

    // A default-slave entry leaves only when the DECERR engine is idle; a
    // mapped entry depends solely on its slave, never on the engine.
    assign ds_start = hold_v_reg & dflt_reg & ds_idle;
    assign out_fire = dflt_reg ? ds_start : (hold_v_reg & |(sel_reg & ARREADY_S));
    assign ARREADY  = ~ARESET & (~hold_v_reg | out_fire);
    assign accept   = ARVALID & ARREADY;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            hold_v_reg <= 1'b0;
            sel_reg    <= '0;
            dflt_reg   <= 1'b0;
        end else if (accept) begin
            hold_v_reg <= 1'b1;
            sel_reg    <= sel_in;
            dflt_reg   <= dflt_in;
        end else if (out_fire) begin
            hold_v_reg <= 1'b0;
        end
    end

    // Payload changes only on a load, so it is stable for the whole time the
    // entry is presented to a stalled slave.
    always_ff @(posedge ACLK) begin
        if (accept) begin
            id_reg    <= id_in;
            addr_reg  <= ARADDR;
            len_reg   <= ARLEN;
            size_reg  <= ARSIZE;
            burst_reg <= ARBURST;
        end
    end

    for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
        assign ARVALID_S[gi]                     = hold_v_reg & sel_reg[gi] & ~dflt_reg;
        assign ARID_S[gi*IDS_W +: IDS_W]         = id_reg;
        assign ARADDR_S[gi*ADDR_W +: ADDR_W]     = addr_reg;
        assign ARLEN_S[gi*LEN_W +: LEN_W]        = len_reg;
        assign ARSIZE_S[gi*SIZE_W +: SIZE_W]     = size_reg;
        assign ARBURST_S[gi*2 +: 2]              = burst_reg;
    end

    // ---------------- default slave ----------------
    axi_default_slave_rd #(
        .IDS_W  (IDS_W),
        .LEN_W  (LEN_W),
        .DATA_W (DATA_W)
    ) u_dflt (
        .clk       (ACLK),
        .srst      (ARESET),
        .start     (ds_start),
        .start_id  (id_reg),
        .start_len (len_reg),
        .idle      (ds_idle),
        .rid       (RID_D),
        .rdata     (RDATA_D),
        .rresp     (RRESP_D),
        .rlast     (RLAST_D),
        .rvalid    (RVALID_D),
        .rready    (RREADY_D)
    );

endmodule

// File: tb/tb_ar_decoder_n.sv
// -----------------------------------------------------------------------------
// tb_ar_decoder_n
// Bench for ar_decoder_n with two slaves (64 KiB windows at 0x0000_0000 and
// 0x0001_0000) and master index 1. A negedge monitor keeps per-slave queues
// of expected AR payloads and a queue of expected DECERR beats, filled from
// the address map at master acceptance; directed sequences add timing checks.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ar_decoder_n;
    import axi_pkg::*;

    localparam int NS     = 2;
    localparam int ADDR_W = 32;
    localparam int ID_W   = 4;
    localparam int IDS_W  = 8;
    localparam int LEN_W  = 4;
    localparam int SIZE_W = 3;
    localparam int DATA_W = 32;
    localparam logic [3:0] MIDX = 4'd1;

    logic                    ACLK = 1'b0;
    logic                    ARESET = 1'b1;
    logic [ID_W-1:0]         ARID = '0;
    logic [ADDR_W-1:0]       ARADDR = '0;
    logic [LEN_W-1:0]        ARLEN = '0;
    logic [SIZE_W-1:0]       ARSIZE = 3'd2;
    logic [1:0]              ARBURST = AXI_BURST_INCR;
    logic                    ARVALID = 1'b0;
    logic                    ARREADY;
    logic [NS*IDS_W-1:0]     ARID_S;
    logic [NS*ADDR_W-1:0]    ARADDR_S;
    logic [NS*LEN_W-1:0]     ARLEN_S;
    logic [NS*SIZE_W-1:0]    ARSIZE_S;
    logic [NS*2-1:0]         ARBURST_S;
    logic [NS-1:0]           ARVALID_S;
    logic [NS-1:0]           ARREADY_S = '0;
    logic [IDS_W-1:0]        RID_D;
    logic [DATA_W-1:0]       RDATA_D;
    logic [1:0]              RRESP_D;
    logic                    RLAST_D;
    logic                    RVALID_D;
    logic                    RREADY_D = 1'b0;

    always #5 ACLK = ~ACLK;

    ar_decoder_n #(
        .NUM_SLAVES (NS),
        .ADDR_W     (ADDR_W),
        .ID_W       (ID_W),
        .IDS_W      (IDS_W),
        .LEN_W      (LEN_W),
        .SIZE_W     (SIZE_W),
        .DATA_W     (DATA_W),
        .MASTER_IDX (MIDX),
        .SLV_BASE   (64'h0001_0000_0000_0000),
        .SLV_MASK   (64'hFFFF_0000_FFFF_0000)
    ) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .ARID      (ARID),
        .ARADDR    (ARADDR),
        .ARLEN     (ARLEN),
        .ARSIZE    (ARSIZE),
        .ARBURST   (ARBURST),
        .ARVALID   (ARVALID),
        .ARREADY   (ARREADY),
        .ARID_S    (ARID_S),
        .ARADDR_S  (ARADDR_S),
        .ARLEN_S   (ARLEN_S),
        .ARSIZE_S  (ARSIZE_S),
        .ARBURST_S (ARBURST_S),
        .ARVALID_S (ARVALID_S),
        .ARREADY_S (ARREADY_S),
        .RID_D     (RID_D),
        .RDATA_D   (RDATA_D),
        .RRESP_D   (RRESP_D),
        .RLAST_D   (RLAST_D),
        .RVALID_D  (RVALID_D),
        .RREADY_D  (RREADY_D)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Region = address / 64 KiB: region 0 -> slave 0, region 1 -> slave 1,
    // anything else -> default slave (-1).
    function automatic int route(input logic [31:0] a);
        int region;
        region = int'(a >> 16);
        if (region == 0) return 0;
        if (region == 1) return 1;
        return -1;
    endfunction

    ar_payload_t exp_s [NS][$];
    logic [8:0]  exp_r [$];          // {last, id}

    int cyc = 0;
    int s0_fire_cycs [$];
    int rlast_hs_cycs [$];
    int burst_start_cycs [$];

    ar_payload_t prev_pay [NS];
    logic [NS-1:0] prev_stall = '0;
    logic prev_rst = 1'b1;
    logic prev_rvalid = 1'b0;

    int rr_mode = 0;   // 0: RREADY_D driven by main, 1: toggle, 2: random
    int as_mode = 0;   // 0: ARREADY_S driven by main, 1: random

    initial forever begin
        @(posedge ACLK); #1;
        if (rr_mode == 2)      RREADY_D = 1'($urandom_range(0, 1));
        else if (rr_mode == 1) RREADY_D = ~RREADY_D;
        if (as_mode == 1)      ARREADY_S = 2'($urandom_range(0, 3));
    end

    // ---------------- monitor / scoreboard ----------------
    initial forever begin
        @(negedge ACLK);
        cyc++;
        for (int i = 0; i < NS; i++) begin
            ar_payload_t p;
            p.id    = ARID_S[i*IDS_W +: IDS_W];
            p.addr  = ARADDR_S[i*ADDR_W +: ADDR_W];
            p.len   = ARLEN_S[i*LEN_W +: LEN_W];
            p.size  = ARSIZE_S[i*SIZE_W +: SIZE_W];
            p.burst = ARBURST_S[i*2 +: 2];
            if (prev_stall[i] && !prev_rst) begin
                check_eq("stall_valid", 64'(ARVALID_S[i]), 64'd1);
                check_eq("stall_payload", 64'(p), 64'(prev_pay[i]));
            end
            if (ARVALID_S[i] && ARREADY_S[i]) begin
                check_eq("slave_ar_expected", 64'(exp_s[i].size() != 0), 64'd1);
                if (exp_s[i].size() != 0) begin
                    ar_payload_t e;
                    e = exp_s[i].pop_front();
                    check_eq("slave_ar_payload", 64'(p), 64'(e));
                end
                if (i == 0) s0_fire_cycs.push_back(cyc);
            end
            prev_stall[i] = ARVALID_S[i] && !ARREADY_S[i];
            prev_pay[i]   = p;
        end

        check_eq("rdata_zero", 64'(RDATA_D), 64'd0);
        check_eq("rresp", 64'(RRESP_D), RVALID_D ? 64'd3 : 64'd0);
        if (RVALID_D && !prev_rvalid) burst_start_cycs.push_back(cyc);
        if (RVALID_D && RREADY_D) begin
            check_eq("r_beat_expected", 64'(exp_r.size() != 0), 64'd1);
            if (exp_r.size() != 0) begin
                logic [8:0] e;
                e = exp_r.pop_front();
                check_eq("r_beat_last_id", 64'({RLAST_D, RID_D}), 64'(e));
            end
            if (RLAST_D) rlast_hs_cycs.push_back(cyc);
        end
        prev_rvalid = RVALID_D && !(RREADY_D && RLAST_D);

        if (ARESET) check_eq("arready_in_reset", 64'(ARREADY), 64'd0);

        if (ARVALID && ARREADY) begin
            int r;
            logic [7:0] id8;
            r   = route(ARADDR);
            id8 = {MIDX, ARID};
            if (r >= 0) begin
                ar_payload_t e;
                e.id = id8; e.addr = ARADDR; e.len = ARLEN; e.size = ARSIZE; e.burst = ARBURST;
                exp_s[r].push_back(e);
            end else begin
                for (int b = 0; b <= int'(ARLEN); b++)
                    exp_r.push_back({b == int'(ARLEN), id8});
            end
            $display("[TB] cyc %0d AR id=%0h addr=%08h len=%0d -> %s", cyc, id8, ARADDR, ARLEN,
                     (r < 0) ? "default" : (r == 0) ? "slave0" : "slave1");
        end

        // Reset drops whatever is held or still owed.
        if (ARESET) begin
            for (int i = 0; i < NS; i++) exp_s[i].delete();
            exp_r.delete();
        end
        prev_rst = ARESET;
    end

    // ---------------- driver helpers ----------------
    task automatic step();
        @(posedge ACLK); #1;
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len);
        int waited;
        waited  = 0;
        ARVALID = 1'b1;
        ARID    = id;
        ARADDR  = addr;
        ARLEN   = len;
        do begin
            @(negedge ACLK);
            waited++;
        end while (!ARREADY && waited < 200);
        check_eq("ar_accepted", 64'(ARREADY), 64'd1);
        step();
        ARVALID = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int waited;

        // Reset state
        ARESET = 1'b1;
        repeat (3) step();
        @(negedge ACLK);
        check_eq("rst_arvalid_s", 64'(ARVALID_S), 64'd0);
        check_eq("rst_rvalid", 64'(RVALID_D), 64'd0);
        check_eq("rst_rlast", 64'(RLAST_D), 64'd0);
        check_eq("rst_rid", 64'(RID_D), 64'd0);
        check_eq("rst_rresp", 64'(RRESP_D), 64'd0);
        check_eq("rst_arready", 64'(ARREADY), 64'd0);
        step();
        ARESET = 1'b0;
        @(negedge ACLK);
        check_eq("post_rst_arready", 64'(ARREADY), 64'd1);
        step();

        // 1: single mapped AR to slave 0
        ARREADY_S = 2'b11;
        send_ar(4'd3, 32'h0000_1234, 4'd0);
        @(negedge ACLK);
        check_eq("t1_arvalid_s", 64'(ARVALID_S), 64'h1);
        check_eq("t1_arid_s0", 64'(ARID_S[7:0]), 64'h13);
        check_eq("t1_araddr_s0", 64'(ARADDR_S[31:0]), 64'h1234);
        check_eq("t1_rvalid", 64'(RVALID_D), 64'd0);
        step();

        // 2: slave 1 stalls 3 cycles while a second AR waits
        ARREADY_S = 2'b01;
        send_ar(4'd2, 32'h0001_0004, 4'd0);
        ARVALID = 1'b1; ARID = 4'd4; ARADDR = 32'h0000_0020; ARLEN = 4'd0;
        for (int k = 0; k < 3; k++) begin
            @(negedge ACLK);
            check_eq("t2_arvalid_s", 64'(ARVALID_S), 64'h2);
            check_eq("t2_araddr_s1", 64'(ARADDR_S[63:32]), 64'h0001_0004);
            check_eq("t2_arready_blocked", 64'(ARREADY), 64'd0);
            step();
        end
        ARREADY_S = 2'b11;
        @(negedge ACLK);
        check_eq("t2_arready_release", 64'(ARREADY), 64'd1);
        step();
        ARVALID = 1'b0;
        @(negedge ACLK);
        check_eq("t2_second_issue", 64'({ARVALID_S, ARADDR_S[31:0]}), 64'({2'b01, 32'h20}));
        step();

        // 3: unmapped AR, 4 DECERR beats
        RREADY_D = 1'b1;
        send_ar(4'd5, 32'h0002_0000, 4'd3);
        @(negedge ACLK);
        check_eq("t3_rvalid_t1", 64'(RVALID_D), 64'd0);
        step();
        for (int b = 0; b < 4; b++) begin
            @(negedge ACLK);
            check_eq("t3_rvalid", 64'(RVALID_D), 64'd1);
            check_eq("t3_rid", 64'(RID_D), 64'h15);
            check_eq("t3_rlast", 64'(RLAST_D), 64'(b == 3));
            check_eq("t3_no_slave_ar", 64'(ARVALID_S), 64'd0);
            step();
        end
        @(negedge ACLK);
        check_eq("t3_rvalid_done", 64'(RVALID_D), 64'd0);
        step();

        // 4: DECERR burst, mapped AR overtakes, second DECERR waits for RLAST
        s0_fire_cycs.delete(); rlast_hs_cycs.delete(); burst_start_cycs.delete();
        rr_mode = 1;
        send_ar(4'd6, 32'h0003_0000, 4'd1);
        send_ar(4'd7, 32'h0000_0010, 4'd0);
        send_ar(4'd8, 32'h8000_0000, 4'd0);
        waited = 0;
        while (rlast_hs_cycs.size() < 2 && waited < 60) begin
            step();
            waited++;
        end
        rr_mode = 0;
        step();
        RREADY_D = 1'b1;
        check_eq("t4_rlast_count", 64'(rlast_hs_cycs.size()), 64'd2);
        check_eq("t4_burst_count", 64'(burst_start_cycs.size()), 64'd2);
        check_eq("t4_s0_count", 64'(s0_fire_cycs.size()), 64'd1);
        if (rlast_hs_cycs.size() >= 1 && s0_fire_cycs.size() >= 1)
            check_eq("t4_mapped_before_rlast", 64'(s0_fire_cycs[0] < rlast_hs_cycs[0]), 64'd1);
        if (rlast_hs_cycs.size() >= 1 && burst_start_cycs.size() >= 2)
            check_eq("t4_second_burst_start", 64'(burst_start_cycs[1]), 64'(rlast_hs_cycs[0] + 2));

        // 5: eight back-to-back ARs to slave 0
        ARREADY_S = 2'b11;
        for (int j = 0; j <= 8; j++) begin
            ARVALID = (j < 8);
            ARADDR  = 32'(4 * j);
            ARID    = 4'(j);
            ARLEN   = 4'd0;
            @(negedge ACLK);
            if (j < 8) check_eq("t5_arready", 64'(ARREADY), 64'd1);
            if (j > 0) check_eq("t5_issue", 64'({ARVALID_S[0], ARADDR_S[31:0]}),
                                64'({1'b1, 32'(4 * (j - 1))}));
            step();
        end
        ARVALID = 1'b0;

        // 6: reset in the middle of a 4-beat DECERR burst
        RREADY_D = 1'b1;
        send_ar(4'd9, 32'h0005_0000, 4'd3);
        waited = 0;
        do begin
            @(negedge ACLK);
            waited++;
        end while (!RVALID_D && waited < 10);
        check_eq("t6_burst_started", 64'(RVALID_D), 64'd1);
        step();          // beat 0 handshaked
        step();          // beat 1 handshaked
        ARESET   = 1'b1;
        RREADY_D = 1'b0;
        @(negedge ACLK);
        check_eq("t6_arready_rst", 64'(ARREADY), 64'd0);
        step();
        @(negedge ACLK);
        check_eq("t6_rvalid_after_rst", 64'(RVALID_D), 64'd0);
        check_eq("t6_arready_rst2", 64'(ARREADY), 64'd0);
        step();
        ARESET = 1'b0;
        @(negedge ACLK);
        check_eq("t6_arready_after_rst", 64'(ARREADY), 64'd1);
        RREADY_D = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            @(negedge ACLK);
            check_eq("t6_no_more_beats", 64'(RVALID_D), 64'd0);
        end
        step();

        // Random traffic against the scoreboard
        rr_mode = 2;
        as_mode = 1;
        for (int n = 0; n < 200; n++) begin
            int region;
            logic [31:0] a;
            repeat ($urandom_range(0, 2)) step();
            region = $urandom_range(0, 2);
            a[15:0] = 16'($urandom);
            if (region == 0)      a[31:16] = 16'h0000;
            else if (region == 1) a[31:16] = 16'h0001;
            else                  a[31:16] = 16'($urandom_range(2, 16'hFFFF));
            ARSIZE  = 3'($urandom_range(0, 2));
            ARBURST = ($urandom_range(0, 1) != 0) ? AXI_BURST_INCR : AXI_BURST_WRAP;
            send_ar(4'($urandom), a, 4'($urandom_range(0, 7)));
        end

        // Drain
        rr_mode = 0;
        as_mode = 0;
        step();
        ARREADY_S = 2'b11;
        RREADY_D  = 1'b1;
        waited = 0;
        while ((exp_s[0].size() + exp_s[1].size() + exp_r.size()) != 0 && waited < 300) begin
            step();
            waited++;
        end
        step();
        check_eq("drain_s0", 64'(exp_s[0].size()), 64'd0);
        check_eq("drain_s1", 64'(exp_s[1].size()), 64'd0);
        check_eq("drain_r", 64'(exp_r.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
